// File: rtl/sha1_padder_if.sv
// sha1_padder_if: stream-in / block-out bundle for the SHA-1 padder.
//   i_tvalid/o_tready/i_tdata/i_tkeep/i_tlast : byte-granular big-endian message words
//   o_tvalid_blk/i_tready_blk                 : padded 512-bit block handshake
//   o_block                                   : 16 words, word 0 in [0]
//   o_first/o_last                            : block is first/last of its message
// master = message source / block sink, slave = padder.
interface sha1_padder_if;
    logic               i_tvalid;
    logic               o_tready;
    logic [31:0]        i_tdata;
    logic [3:0]         i_tkeep;
    logic               i_tlast;
    logic               o_tvalid_blk;
    logic               i_tready_blk;
    logic [15:0][31:0]  o_block;
    logic               o_first;
    logic               o_last;

    modport master (
        output i_tvalid, i_tdata, i_tkeep, i_tlast, i_tready_blk,
        input  o_tready, o_tvalid_blk, o_block, o_first, o_last
    );

    modport slave (
        input  i_tvalid, i_tdata, i_tkeep, i_tlast, i_tready_blk,
        output o_tready, o_tvalid_blk, o_block, o_first, o_last
    );
endinterface

// File: rtl/sha1_padder.sv
// sha1_padder: applies SHA-1 padding (0x80, zero fill, 64-bit bit length) to a
// byte-granular 32-bit big-endian message stream and emits 512-bit blocks.
//   clk     : clock
//   reset_n : asynchronous active-low reset
//   bus     : sha1_padder_if.slave (input stream, block output with first/last flags)
// One input or pad word is written per cycle into a single block buffer; the
// buffer is presented until the downstream handshake completes.
module sha1_padder #(
    parameter int unsigned CNT_W = 61
) (
    input  logic          clk,
    input  logic          reset_n,
    sha1_padder_if.slave  bus
);

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        LEN  = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         widx_q, widx_d;
    logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic               first_pend_q, first_pend_d;
    logic               pad80_done_q, pad80_done_d;
    logic               final_q, final_d;
    // message has ended but its length did not fit in the current block
    logic               msg_end_q, msg_end_d;
    logic [15:0][31:0]  blk_q, blk_d;

    logic [2:0]         keep_cnt;
    logic [31:0]        keep_mask;
    logic [31:0]        in_word;
    logic [31:0]        pad_word;
    logic [63:0]        len;

    assign keep_cnt  = {2'b00, bus.i_tkeep[3]} + {2'b00, bus.i_tkeep[2]}
                     + {2'b00, bus.i_tkeep[1]} + {2'b00, bus.i_tkeep[0]};
    assign keep_mask = {{8{bus.i_tkeep[3]}}, {8{bus.i_tkeep[2]}},
                        {8{bus.i_tkeep[1]}}, {8{bus.i_tkeep[0]}}};
    assign pad_word  = pad80_done_q ? '0 : 32'h8000_0000;
    assign len       = 64'({byte_cnt_q, 3'b000});

    // Partial tail: the 0x80 marker lands in the first byte after the valid ones,
    // which is the MSB shifted right by one byte per valid byte.
    always_comb begin
        in_word = bus.i_tdata & keep_mask;
        if (bus.i_tlast && bus.i_tkeep != 4'b1111) begin
            in_word = in_word | (32'h8000_0000 >> {keep_cnt, 3'b000});
        end
    end

    always_comb begin
        state_d      = state_q;
        widx_d       = widx_q;
        byte_cnt_d   = byte_cnt_q;
        first_pend_d = first_pend_q;
        pad80_done_d = pad80_done_q;
        final_d      = final_q;
        msg_end_d    = msg_end_q;
        blk_d        = blk_q;

        case (state_q)
            FILL: begin
                if (bus.i_tvalid) begin
                    blk_d[widx_q] = in_word;
                    byte_cnt_d    = byte_cnt_q + CNT_W'(keep_cnt);
                    widx_d        = widx_q + 4'd1;
                    if (bus.i_tlast && bus.i_tkeep != 4'b1111) begin
                        pad80_done_d = 1'b1;
                    end
                    if (widx_q == 4'd15) begin
                        state_d   = OUT;
                        msg_end_d = bus.i_tlast;
                    end else if (bus.i_tlast) begin
                        // a partial 14th word already carries 0x80: length fits now
                        state_d = (widx_q == 4'd13 && pad80_done_d) ? LEN : PAD;
                    end
                end
            end
            PAD: begin
                if (widx_q == 4'd14 && pad80_done_q) begin
                    state_d = LEN;
                end else begin
                    blk_d[widx_q] = pad_word;
                    pad80_done_d  = 1'b1;
                    widx_d        = widx_q + 4'd1;
                    if (widx_q == 4'd13) begin
                        state_d = LEN;
                    end else if (widx_q == 4'd15) begin
                        state_d   = OUT;
                        msg_end_d = 1'b1;
                    end
                end
            end
            LEN: begin
                blk_d[14] = len[63:32];
                blk_d[15] = len[31:0];
                final_d   = 1'b1;
                state_d   = OUT;
            end
            OUT: begin
                if (bus.i_tready_blk) begin
                    widx_d       = '0;
                    first_pend_d = 1'b0;
                    if (final_q) begin
                        state_d      = FILL;
                        byte_cnt_d   = '0;
                        pad80_done_d = 1'b0;
                        first_pend_d = 1'b1;
                        final_d      = 1'b0;
                    end else if (msg_end_q) begin
                        state_d   = PAD;
                        msg_end_d = 1'b0;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= FILL;
            widx_q       <= '0;
            byte_cnt_q   <= '0;
            first_pend_q <= 1'b1;
            pad80_done_q <= 1'b0;
            final_q      <= 1'b0;
            msg_end_q    <= 1'b0;
            blk_q        <= '0;
        end else begin
            state_q      <= state_d;
            widx_q       <= widx_d;
            byte_cnt_q   <= byte_cnt_d;
            first_pend_q <= first_pend_d;
            pad80_done_q <= pad80_done_d;
            final_q      <= final_d;
            msg_end_q    <= msg_end_d;
            blk_q        <= blk_d;
        end
    end

    assign bus.o_tready     = (state_q == FILL);
    assign bus.o_tvalid_blk = (state_q == OUT);
    assign bus.o_first      = (state_q == OUT) && first_pend_q;
    assign bus.o_last       = (state_q == OUT) && final_q;
    assign bus.o_block      = blk_q;

endmodule

// File: tb/tb_sha1_padder.sv
// tb_sha1_padder: directed self-checking bench for sha1_padder.
module tb_sha1_padder;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;
    int   cyc;
    logic [15:0][31:0] exp_blk;
    logic [15:0][31:0] exp_a;

    sha1_padder_if bus ();

    sha1_padder #(.CNT_W(61)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n;
        n = 0;
        while (!bus.o_tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.o_tready) chk("send_tready_timeout", 64'(bus.o_tready), 64'd1);
        bus.i_tvalid = 1'b1;
        bus.i_tdata  = d;
        bus.i_tkeep  = k;
        bus.i_tlast  = l;
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        bus.i_tlast  = 1'b0;
    endtask

    // cycles counted from #1 after the last accepting edge
    task automatic wait_blk(output int cycles);
        cycles = 0;
        while (!bus.o_tvalid_blk && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        if (!bus.o_tvalid_blk) chk("blk_valid_timeout", 64'(bus.o_tvalid_blk), 64'd1);
    endtask

    task automatic check_blk(input string tag, input logic [15:0][31:0] e,
                             input logic f, input logic l);
        for (int unsigned w = 0; w < 16; w++) begin
            chk($sformatf("%s_w%0d", tag, w), 64'(bus.o_block[w]), 64'(e[w]));
        end
        chk({tag, "_first"}, 64'(bus.o_first), 64'(f));
        chk({tag, "_last"}, 64'(bus.o_last), 64'(l));
    endtask

    task automatic take_blk();
        bus.i_tready_blk = 1'b1;
        @(posedge clk); #1;
        bus.i_tready_blk = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        bus.i_tvalid     = 1'b0;
        bus.i_tdata      = '0;
        bus.i_tkeep      = '0;
        bus.i_tlast      = 1'b0;
        bus.i_tready_blk = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // reset state
        chk("rst_tvalid_blk", 64'(bus.o_tvalid_blk), 64'd0);
        chk("rst_tready", 64'(bus.o_tready), 64'd1);
        chk("rst_first", 64'(bus.o_first), 64'd0);
        chk("rst_last", 64'(bus.o_last), 64'd0);
        chk("rst_block_lo", bus.o_block[1:0], 64'd0);
        chk("rst_block_hi", bus.o_block[15:14], 64'd0);

        // "abc"
        exp_a = '0;
        exp_a[0]  = 32'h6162_6380;
        exp_a[15] = 32'h0000_0018;
        send(32'h6162_6300, 4'b1110, 1'b1);
        wait_blk(cyc);
        chk("abc_latency", 64'(cyc), 64'd14);
        check_blk("abc", exp_a, 1'b1, 1'b1);
        take_blk();

        // empty message
        exp_blk = '0;
        exp_blk[0] = 32'h8000_0000;
        send(32'hDEAD_BEEF, 4'b0000, 1'b1);
        wait_blk(cyc);
        check_blk("empty", exp_blk, 1'b1, 1'b1);
        take_blk();

        // 5 bytes, garbage below keep must be masked
        exp_blk = '0;
        exp_blk[0]  = 32'h4142_4344;
        exp_blk[1]  = 32'h4580_0000;
        exp_blk[15] = 32'h0000_0028;
        send(32'h4142_4344, 4'b1111, 1'b0);
        send(32'h45FF_FFFF, 4'b1000, 1'b1);
        wait_blk(cyc);
        check_blk("b5", exp_blk, 1'b1, 1'b1);
        take_blk();

        // 55 bytes: length still fits in the same block
        exp_blk = '0;
        for (int unsigned i = 0; i < 13; i++) begin
            send(32'h1020_3040 + 32'(i), 4'b1111, 1'b0);
            exp_blk[i] = 32'h1020_3040 + 32'(i);
        end
        send(32'hA1B2_C3D4, 4'b1110, 1'b1);
        exp_blk[13] = 32'hA1B2_C380;
        exp_blk[15] = 32'h0000_01B8;
        wait_blk(cyc);
        check_blk("b55", exp_blk, 1'b1, 1'b1);
        take_blk();

        // 56 bytes: two blocks
        exp_blk = '0;
        for (int unsigned i = 0; i < 14; i++) begin
            send(32'h5500_0000 + 32'(i), 4'b1111, (i == 13));
            exp_blk[i] = 32'h5500_0000 + 32'(i);
        end
        exp_blk[14] = 32'h8000_0000;
        wait_blk(cyc);
        check_blk("b56a", exp_blk, 1'b1, 1'b0);
        take_blk();
        exp_blk = '0;
        exp_blk[15] = 32'h0000_01C0;
        wait_blk(cyc);
        check_blk("b56b", exp_blk, 1'b0, 1'b1);
        take_blk();

        // 64 bytes: two blocks
        exp_blk = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            send(32'hC0DE_0000 + 32'(i), 4'b1111, (i == 15));
            exp_blk[i] = 32'hC0DE_0000 + 32'(i);
        end
        wait_blk(cyc);
        check_blk("b64a", exp_blk, 1'b1, 1'b0);
        take_blk();
        exp_blk = '0;
        exp_blk[0]  = 32'h8000_0000;
        exp_blk[15] = 32'h0000_0200;
        wait_blk(cyc);
        check_blk("b64b", exp_blk, 1'b0, 1'b1);
        take_blk();

        // backpressure: block held stable for 20 cycles
        send(32'h6162_6300, 4'b1110, 1'b1);
        wait_blk(cyc);
        for (int unsigned i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("bp_valid", 64'(bus.o_tvalid_blk), 64'd1);
            chk("bp_tready", 64'(bus.o_tready), 64'd0);
            chk("bp_w0", 64'(bus.o_block[0]), 64'(exp_a[0]));
            chk("bp_w15", 64'(bus.o_block[15]), 64'(exp_a[15]));
            chk("bp_first", 64'(bus.o_first), 64'd1);
            chk("bp_last", 64'(bus.o_last), 64'd1);
        end
        take_blk();
        send(32'h6162_6300, 4'b1110, 1'b1);
        wait_blk(cyc);
        chk("abc2_latency", 64'(cyc), 64'd14);
        check_blk("abc2", exp_a, 1'b1, 1'b1);
        take_blk();

        // reset during PAD of a 3-word message
        send(32'h1111_1111, 4'b1111, 1'b0);
        send(32'h2222_2222, 4'b1111, 1'b0);
        send(32'h3333_3333, 4'b1111, 1'b1);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_valid_async", 64'(bus.o_tvalid_blk), 64'd0);
        chk("mrst_tready_async", 64'(bus.o_tready), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("mrst_valid", 64'(bus.o_tvalid_blk), 64'd0);
        chk("mrst_tready", 64'(bus.o_tready), 64'd1);
        send(32'h6162_6300, 4'b1110, 1'b1);
        wait_blk(cyc);
        chk("abc3_latency", 64'(cyc), 64'd14);
        check_blk("abc3", exp_a, 1'b1, 1'b1);
        take_blk();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
